// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline: data width, reset PC, the
// canonical NOP used for bubbles, the fetch FSM states and the register
// field positions decode/hazard logic extract from an instruction word.
package pipeline_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  load enable (driven by !StallD)
//   clr                 synchronous clear to a bubble, wins over en (FlushD)
//   instr_next..valid_next  values to capture
//   instr, pc, pc_plus4, valid  registered outputs
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN      = pipeline_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic [31:0]     instr_next,
  input  logic [XLEN-1:0] pc_next,
  input  logic [XLEN-1:0] pc_plus4_next,
  input  logic            valid_next,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (clr) begin
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (en) begin
      instr    <= instr_next;
      pc       <= pc_next;
      pc_plus4 <= pc_plus4_next;
      valid    <= valid_next;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register.
// Owns PCF, drives a variable-latency req/ready instruction memory port and
// presents InstrD/PCD/PCPlus4D/ValidD (+ Rs1_D/Rs2_D) to decode.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   StallF, StallD, FlushD     hazard controls
//   PCSrcE, PCTargetE          redirect from execute
//   imem_req, imem_addr        fetch request / address (= PCF)
//   imem_ready, imem_rdata     completion strobe / instruction word
//   InstrD, PCD, PCPlus4D, ValidD, Rs1_D, Rs2_D   decode-side outputs
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN      = pipeline_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(pipeline_pkg::RESET_PC),
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic [4:0]      Rs1_D,
  output logic [4:0]      Rs2_D
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pcf, pcf_next;
  logic [XLEN-1:0] redir_pc, redir_pc_next;
  logic            redir_pending, redir_pending_next;
  logic [31:0]     hold_instr, hold_instr_next;
  logic [XLEN-1:0] pcf_plus4;
  logic            complete;

  logic [31:0]     ifid_instr;
  logic [XLEN-1:0] ifid_pc, ifid_pc_plus4;
  logic            ifid_valid;

  assign imem_req  = (state == REQ);
  assign imem_addr = pcf;
  assign complete  = (state == REQ) && imem_ready;
  assign pcf_plus4 = pcf + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pcf           <= RESET_PC;
      redir_pc      <= '0;
      redir_pending <= 1'b0;
      hold_instr    <= '0;
    end else begin
      state         <= state_next;
      pcf           <= pcf_next;
      redir_pc      <= redir_pc_next;
      redir_pending <= redir_pending_next;
      hold_instr    <= hold_instr_next;
    end
  end

  always_comb begin
    state_next         = state;
    pcf_next           = pcf;
    redir_pc_next      = redir_pc;
    redir_pending_next = redir_pending;
    hold_instr_next    = hold_instr;
    // IF/ID sees a bubble unless a word is actually delivered this cycle
    ifid_instr    = NOP_INSTR;
    ifid_pc       = '0;
    ifid_pc_plus4 = '0;
    ifid_valid    = 1'b0;

    case (state)
      IDLE: begin
        state_next = REQ;
        if (PCSrcE) pcf_next = PCTargetE;
      end
      REQ: begin
        if (PCSrcE) begin
          if (imem_ready) begin
            pcf_next           = PCTargetE;
            redir_pending_next = 1'b0;
          end else begin
            // address must stay put until the outstanding fetch completes
            redir_pc_next      = PCTargetE;
            redir_pending_next = 1'b1;
          end
        end else if (complete && redir_pending) begin
          pcf_next           = redir_pc;
          redir_pending_next = 1'b0;
        end else if (complete) begin
          // a word completing while either side is held is parked, not lost
          if (StallF || StallD) begin
            hold_instr_next = imem_rdata;
            state_next      = HOLD;
          end else begin
            ifid_instr    = imem_rdata;
            ifid_pc       = pcf;
            ifid_pc_plus4 = pcf_plus4;
            ifid_valid    = 1'b1;
            pcf_next      = pcf_plus4;
          end
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pcf_next   = PCTargetE;
          state_next = REQ;
        end else if (!StallF && !StallD) begin
          ifid_instr    = hold_instr;
          ifid_pc       = pcf;
          ifid_pc_plus4 = pcf_plus4;
          ifid_valid    = 1'b1;
          pcf_next      = pcf_plus4;
          state_next    = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (!StallD),
    .clr           (FlushD),
    .instr_next    (ifid_instr),
    .pc_next       (ifid_pc),
    .pc_plus4_next (ifid_pc_plus4),
    .valid_next    (ifid_valid),
    .instr         (InstrD),
    .pc            (PCD),
    .pc_plus4      (PCPlus4D),
    .valid         (ValidD)
  );

  assign Rs1_D = InstrD[RS1_LSB +: 5];
  assign Rs2_D = InstrD[RS2_LSB +: 5];

endmodule
